// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle, magnitudes in CALC, sign correction in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH-1:0]     a_raw;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;

  always_comb begin
    a_mag    = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag    = (op[0] && b[WIDTH-1]) ? -b : b;
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
    // Trial subtract of the partial remainder shifted left by one.
    sub_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
    step_acc = '0;
    if (is_div) begin
      if (sub_diff[WIDTH]) step_acc = {acc[2*WIDTH-2:0], 1'b0};
      else                 step_acc = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0]) step_acc = {add_sum, acc[WIDTH-1:1]};
      else        step_acc = {1'b0, acc[2*WIDTH-1:1]};
    end
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      a_raw  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            is_div <= op[1];
            neg_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op[0] & a[WIDTH-1];
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            a_raw  <= a;
            div0   <= 1'b0;
            cnt    <= CW'(WIDTH);
          end
        end
        CALC: begin
          acc <= step_acc;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero ignores the iteration result entirely.
            if (opb == '0) begin
              hi   <= a_raw;
              lo   <= '1;
              div0 <= 1'b1;
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: 32-bit and 8-bit instances driven with directed and random
// operations; results checked against an arithmetic reference through expected queues.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // 32-bit instance
  logic        start, hi_we, lo_we, busy, done, div0;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  // 8-bit instance
  logic        s_start, s_hi_we, s_lo_we, s_busy, s_done, s_div0;
  logic [1:0]  s_op;
  logic [7:0]  s_a, s_b, s_wdata, s_hi, s_lo;

  logic [64:0] exp_q[$];
  int          t_q[$];
  logic [64:0] exp8_q[$];
  int          t8_q[$];

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
    .hi_we(s_hi_we), .lo_we(s_lo_we), .wdata(s_wdata),
    .busy(s_busy), .done(s_done), .div0(s_div0), .hi(s_hi), .lo(s_lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on w-bit operands; returns {div0, hi, lo}.
  function automatic logic [64:0] model(input int w, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    longint unsigned mask, ux, uy, p;
    longint          sx, sy, q, r;
    logic [31:0]     h, l;
    logic            z;
    mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    ux = {32'b0, x} & mask;
    uy = {32'b0, y} & mask;
    sx = x[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = y[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    z = 1'b0;
    h = '0;
    l = '0;
    if (!o[1]) begin
      p = o[0] ? $unsigned(sx * sy) : ux * uy;
      h = 32'((p >> w) & mask);
      l = 32'(p & mask);
    end else if (uy == 0) begin
      h = 32'(ux);
      l = 32'(mask);
      z = 1'b1;
    end else begin
      if (o[0]) begin
        q = sx / sy;
        r = sx % sy;
      end else begin
        q = longint'(ux / uy);
        r = longint'(ux % uy);
      end
      h = 32'($unsigned(r) & mask);
      l = 32'($unsigned(q) & mask);
    end
    return {z, h, l};
  endfunction

  // driver tasks (called at a falling edge)
  task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("issue32_wait_idle", 72'(busy), 72'(0));
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(32, o, x, y));
    t_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    while (s_busy && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("issue8_wait_idle", 72'(s_busy), 72'(0));
    s_op = o; s_a = x; s_b = y; s_start = 1'b1;
    exp8_q.push_back(model(8, o, {24'b0, x}, {24'b0, y}));
    t8_q.push_back(cyc + 1);
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_q.size() > 0 || exp8_q.size() > 0) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("drain_timeout", 72'(exp_q.size() + exp8_q.size()), 72'(0));
    @(negedge clk);
  endtask

  // scoreboard monitors
  logic [64:0] e32, e8;
  int          t32, t8;

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL done32_unexpected: got done=1 expected no pending operation");
      end else begin
        e32 = exp_q.pop_front();
        t32 = t_q.pop_front();
        check("result32", 72'({div0, hi, lo}), 72'(e32));
        check("latency32", 72'(cyc - t32), 72'(33));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_done) begin
      if (exp8_q.size() == 0) begin
        n_total++;
        $display("FAIL done8_unexpected: got done=1 expected no pending operation");
      end else begin
        e8 = exp8_q.pop_front();
        t8 = t8_q.pop_front();
        check("result8", 72'({s_div0, s_hi, s_lo}), 72'({e8[64], e8[39:32], e8[7:0]}));
        check("latency8", 72'(cyc - t8), 72'(9));
      end
    end
  end

  function automatic logic [31:0] rnd_operand(input int w);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h1 << (w - 1);
      3: v = $urandom_range(0, 9);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  logic [31:0] hi_keep;

  initial begin
    start = 0; op = 0; a = 0; b = 0; hi_we = 0; lo_we = 0; wdata = 0;
    s_start = 0; s_op = 0; s_a = 0; s_b = 0; s_hi_we = 0; s_lo_we = 0; s_wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset32_outputs", 72'({busy, done, div0, hi, lo}), 72'(0));
    check("reset8_outputs", 72'({s_busy, s_done, s_div0, s_hi, s_lo}), 72'(0));
    rst_n = 1'b1;

    // 8-bit instance
    issue8(2'b01, 8'hFD, 8'h05);
    drain();
    check("mult8_hi", 72'(s_hi), 72'(8'hFF));
    check("mult8_lo", 72'(s_lo), 72'(8'hF1));
    issue8(2'b00, 8'hFF, 8'hFF);
    drain();
    check("multu8_hilo", 72'({s_hi, s_lo}), 72'(16'hFE01));
    for (int i = 0; i < 30; i++) begin
      logic [31:0] x, y;
      x = rnd_operand(8);
      y = rnd_operand(8);
      issue8(2'($urandom_range(0, 3)), x[7:0], y[7:0]);
    end
    drain();

    // 32-bit directed
    issue32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    check("multu_hi", 72'(hi), 72'(32'hFFFF_FFFE));
    check("multu_lo", 72'(lo), 72'(32'h0000_0001));
    issue32(2'b01, 32'hFFFF_FFFD, 32'd5);
    drain();
    check("mult_neg", 72'({hi, lo}), 72'(64'hFFFF_FFFF_FFFF_FFF1));
    issue32(2'b11, 32'hFFFF_FFF9, 32'd2);
    drain();
    check("div_neg", 72'({hi, lo}), 72'(64'hFFFF_FFFF_FFFF_FFFD));
    issue32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    check("div_minint", 72'({div0, hi, lo}), 72'({1'b0, 64'h0000_0000_8000_0000}));
    issue32(2'b10, 32'd7, 32'd0);
    drain();
    check("divu_zero", 72'({div0, hi, lo}), 72'({1'b1, 64'h0000_0007_FFFF_FFFF}));
    issue32(2'b00, 32'd3, 32'd4);
    check("div0_cleared", 72'(div0), 72'(0));
    drain();

    // busy interlock: second start and MTHI land at E5 and must be ignored
    issue32(2'b00, 32'h1234_5678, 32'd9);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd3; hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    drain();
    hi_keep = 32'h0000_0000;
    check("interlock_hi", 72'(hi), 72'(hi_keep));
    check("interlock_lo", 72'(lo), 72'(32'hA3D7_0A38));
    lo_we = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 72'(lo), 72'(32'hCAFE));
    check("mtlo_hi_kept", 72'(hi), 72'(hi_keep));
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", 72'({hi, lo}), 72'(64'h0000_0055_0000_0055));

    // asynchronous reset in the middle of a multiply
    issue32(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midop_reset", 72'({busy, done, div0, hi, lo}), 72'(0));
    exp_q.delete();
    t_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue32(2'b10, 32'd100, 32'd7);
    drain();
    check("divu_after_reset", 72'({hi, lo}), 72'({32'd2, 32'd14}));

    // random 32-bit, back-to-back where possible
    for (int i = 0; i < 40; i++)
      issue32(2'($urandom_range(0, 3)), rnd_operand(32), rnd_operand(32));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
